lsu: RTL and testbench

Load/store unit between the execute stage and data memory. It takes one RV32I load or store per request and drives a word-addressed memory port with byte enables. For loads it extracts and sign- or zero-extends the addressed byte or halfword. The registered `load_data` result feeds the writeback select mux's memory-data input.

---
 rtl/lsu_pkg.sv | 57 +++++
 rtl/lsu_load_align.sv | 36 +++
 rtl/lsu.sv | 113 +++++++++++
 tb/tb_lsu.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, RV32I width codes,
// and the byte-enable / write-data lane generators.
package lsu_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StResp = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Width is carried in funct3[1:0]; the sign bit funct3[2] does not affect lanes.
  function automatic logic [3:0] be_gen(input logic [2:0] funct3, input logic [1:0] off);
    logic [3:0] be;
    case (funct3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] wdata_gen(input logic [2:0] funct3, input logic [31:0] sdata);
    logic [31:0] wd;
    case (funct3[1:0])
      2'b00:   wd = {4{sdata[7:0]}};
      2'b01:   wd = {2{sdata[15:0]}};
      default: wd = sdata;
    endcase
    return wd;
  endfunction

  function automatic logic access_illegal(input logic       is_store,
                                          input logic [2:0] funct3,
                                          input logic [1:0] off);
    logic bad;
    case (funct3)
      F3_B, F3_BU: bad = 1'b0;
      F3_H, F3_HU: bad = off[0];
      F3_W:        bad = (off != 2'b00);
      default:     bad = 1'b1;
    endcase
    // Stores have no unsigned variants.
    if (is_store && funct3[2]) begin
      bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte or halfword from a memory word and sign- or zero-extends it.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (off)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    data = rdata;
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'h0, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'h0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one RV32I access, drives a word-addressed memory port with
// byte enables, and returns an extended, registered load result.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          ready,
  input  logic          is_store,
  input  logic [2:0]    funct3,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   store_data,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-3:0] mem_addr,
  output logic [3:0]    mem_be,
  output logic [31:0]   mem_wdata,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [31:0]   mem_rdata,
  output logic          done,
  output logic          err,
  output logic [31:0]   load_data
);

  lsu_state_t    state_q, state_d;
  logic          is_store_q;
  logic [2:0]    funct3_q;
  logic [1:0]    off_q;
  logic          err_q;
  logic [AW-3:0] addr_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;
  logic [31:0]   load_data_q;
  logic [31:0]   align_data;

  logic accept;
  logic illegal;
  logic capture;

  assign accept  = req_valid && (state_q == StIdle);
  assign illegal = access_illegal(is_store, funct3, addr[1:0]);
  assign capture = (state_q == StWait) && mem_rvalid;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = illegal ? StResp : StReq;
      StReq:  if (mem_gnt) state_d = is_store_q ? StResp : StWait;
      StWait: if (mem_rvalid) state_d = StResp;
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Request fields are frozen at acceptance so the memory port stays stable while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_store_q <= 1'b0;
      funct3_q   <= 3'b000;
      off_q      <= 2'b00;
      err_q      <= 1'b0;
      addr_q     <= '0;
      be_q       <= 4'b0000;
      wdata_q    <= 32'h0;
    end else if (accept) begin
      is_store_q <= is_store;
      funct3_q   <= funct3;
      off_q      <= addr[1:0];
      err_q      <= illegal;
      addr_q     <= addr[AW-1:2];
      be_q       <= illegal ? 4'b0000 : be_gen(funct3, addr[1:0]);
      wdata_q    <= wdata_gen(funct3, store_data);
    end
  end

  lsu_load_align u_load_align (
    .rdata  (mem_rdata),
    .funct3 (funct3_q),
    .off    (off_q),
    .data   (align_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_data_q <= 32'h0;
    end else if (capture) begin
      load_data_q <= align_data;
    end
  end

  assign ready     = (state_q == StIdle);
  assign mem_req   = (state_q == StReq);
  assign mem_we    = mem_req && is_store_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign done      = (state_q == StResp);
  assign err       = done && err_q;
  assign load_data = load_data_q;

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for the load/store unit.
module tb_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        ready;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        done;
  logic        err;
  logic [31:0] load_data;

  int n_tests;
  int n_fail;

  lsu #(.AW(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .ready      (ready),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .done       (done),
    .err        (err),
    .load_data  (load_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle; returns in cycle 1 after acceptance.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd);
    req_valid  = 1'b1;
    is_store   = st;
    funct3     = f3;
    addr       = a;
    store_data = sd;
    step();
    req_valid  = 1'b0;
    addr       = 32'hFFFF_FFFF;
    store_data = 32'h0;
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd);
    issue(1'b1, f3, a, sd);
    check_eq({tag, " req/we"}, {30'h0, mem_req, mem_we}, 32'h3);
    check_eq({tag, " addr"}, {2'b00, mem_addr}, a >> 2);
    check_eq({tag, " be"}, {28'h0, mem_be}, {28'h0, exp_be});
    check_eq({tag, " wdata"}, mem_wdata, exp_wd);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    check_eq({tag, " done/err/req"}, {29'h0, done, err, mem_req}, 32'h4);
    step();
    check_eq({tag, " ready/done"}, {30'h0, ready, done}, 32'h2);
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rd, input logic [31:0] exp);
    issue(1'b0, f3, a, 32'h0);
    check_eq({tag, " req/we"}, {30'h0, mem_req, mem_we}, 32'h2);
    mem_gnt = 1'b1;
    step();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = rd;
    step();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    check_eq({tag, " done/err"}, {30'h0, done, err}, 32'h2);
    check_eq({tag, " load_data"}, load_data, exp);
    step();
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    is_store   = 1'b0;
    funct3     = 3'b000;
    addr       = 32'h0;
    store_data = 32'h0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    step();
    step();
    check_eq("reset ctl", {27'h0, ready, mem_req, mem_we, done, err}, 32'h10);
    check_eq("reset be", {28'h0, mem_be}, 32'h0);
    check_eq("reset addr", {2'b00, mem_addr}, 32'h0);
    check_eq("reset wdata", mem_wdata, 32'h0);
    check_eq("reset load_data", load_data, 32'h0);
    rst_n = 1'b1;
    step();

    do_store("sw", 3'b010, 32'h100, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    do_store("sb", 3'b000, 32'h103, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5);
    do_store("sh", 3'b001, 32'h102, 32'h1234_BEEF, 4'b1100, 32'hBEEF_BEEF);

    do_load("lb", 3'b000, 32'h202, 32'h12F0_3456, 32'hFFFF_FFF0);
    do_load("lbu", 3'b100, 32'h202, 32'h12F0_3456, 32'h0000_00F0);
    do_load("lhu", 3'b101, 32'h200, 32'h12F0_8456, 32'h0000_8456);
    do_load("lh lo", 3'b001, 32'h200, 32'h12F0_8456, 32'hFFFF_8456);
    do_load("lh", 3'b001, 32'h202, 32'h12F0_3456, 32'h0000_12F0);

    // Illegal accesses: no memory request, immediate done+err, load_data held.
    issue(1'b0, 3'b010, 32'h7, 32'h0);
    check_eq("lw mis ctl", {29'h0, mem_req, done, err}, 32'h3);
    check_eq("lw mis load_data", load_data, 32'h0000_12F0);
    step();
    check_eq("lw mis after", {29'h0, ready, done, err}, 32'h4);
    issue(1'b0, 3'b001, 32'h5, 32'h0);
    check_eq("lh mis ctl", {29'h0, mem_req, done, err}, 32'h3);
    step();
    issue(1'b0, 3'b011, 32'h8, 32'h0);
    check_eq("bad f3 ctl", {29'h0, mem_req, done, err}, 32'h3);
    step();
    issue(1'b1, 3'b100, 32'h8, 32'h0);
    check_eq("sbu ctl", {29'h0, mem_req, done, err}, 32'h3);
    check_eq("err load_data", load_data, 32'h0000_12F0);
    step();

    // Grant stalled 3 cycles; a stray rvalid in the grant cycle must be ignored.
    issue(1'b0, 3'b010, 32'h300, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check_eq("stall ctl", {27'h0, mem_req, mem_we, done, ready, err}, 32'h10);
      check_eq("stall addr", {2'b00, mem_addr}, 32'hC0);
      check_eq("stall be", {28'h0, mem_be}, 32'hF);
      step();
    end
    mem_gnt    = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5555_5555;
    check_eq("gnt cycle req", {31'h0, mem_req}, 32'h1);
    step();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    check_eq("wait1 done/req", {30'h0, done, mem_req}, 32'h0);
    step();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE_F00D;
    check_eq("wait2 done", {31'h0, done}, 32'h0);
    step();
    mem_rvalid = 1'b0;
    check_eq("stall done", {30'h0, done, err}, 32'h2);
    check_eq("stall load_data", load_data, 32'hCAFE_F00D);
    step();
    check_eq("stall single done", {30'h0, ready, done}, 32'h2);

    // Reset while waiting for read data abandons the access.
    issue(1'b0, 3'b010, 32'h400, 32'h0);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    rst_n   = 1'b0;
    #1;
    check_eq("rst wait ctl", {29'h0, ready, done, mem_req}, 32'h4);
    step();
    rst_n = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1111_2222;
    step();
    mem_rvalid = 1'b0;
    check_eq("stray rvalid ctl", {29'h0, ready, done, err}, 32'h4);
    check_eq("stray rvalid data", load_data, 32'h0);
    step();
    check_eq("post rst done", {30'h0, ready, done}, 32'h2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
